// File: rtl/rifl_fifo_rd_to_axis.sv
// rifl_fifo_rd_to_axis: credit-based prefetch from a fixed-latency FIFO read port into an AXI-Stream master
module rifl_fifo_rd_to_axis #(
  parameter int DWIDTH = 32,
  parameter int RD_LATENCY = 1,
  localparam int BUF_DEPTH = RD_LATENCY + 2,
  localparam int CW = $clog2(BUF_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              fifo_rd_en,
  input  logic [DWIDTH-1:0] fifo_rd_data,
  input  logic              fifo_empty,
  output logic [DWIDTH-1:0] m_axis_tdata,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic [CW-1:0]     buf_cnt
);
  localparam int PW = $clog2(BUF_DEPTH);
  localparam logic [PW-1:0] LAST = PW'(BUF_DEPTH - 1);
  localparam logic [CW:0] DEPTH_W = (CW + 1)'(BUF_DEPTH);
  logic [DWIDTH-1:0] mem [BUF_DEPTH];
  logic [RD_LATENCY-1:0] pipe;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW:0] inflight;
  logic capture, pop;
  // reads issued but not yet returned by the FIFO
  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LATENCY; i++) inflight = inflight + (CW + 1)'(pipe[i]);
  end
  assign capture = pipe[RD_LATENCY-1];
  assign m_axis_tvalid = buf_cnt != '0;
  assign pop = m_axis_tvalid & m_axis_tready;
  assign m_axis_tdata = m_axis_tvalid ? mem[rd_ptr] : '0;
  // credit check on registered state only, so tready never reaches rd_en
  assign fifo_rd_en = rst_n & ~fifo_empty & (((CW + 1)'(buf_cnt) + inflight) < DEPTH_W);
  // in-flight pipe, occupancy and wrapping pointers
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pipe <= '0;
      buf_cnt <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      pipe <= (pipe << 1) | RD_LATENCY'(fifo_rd_en);
      buf_cnt <= buf_cnt + CW'(capture) - CW'(pop);
      if (capture) wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
      if (pop) rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
    end
  // data storage needs no reset: tdata is gated by tvalid
  always_ff @(posedge clk)
    if (capture) mem[wr_ptr] <= fifo_rd_data;
endmodule

// File: doc/rifl_fifo_rd_to_axis.md
Name: rifl_fifo_rd_to_axis

Overview:
Read-side adapter that drains a standard (non-first-word-fall-through) FIFO read port into an AXI-Stream master.
- FIFO port: rd_en, then data RD_LATENCY cycles later, plus empty flag.
- Issues FIFO reads on a credit basis into a small prefetch buffer, so the stream runs at full throughput.
- No combinational path from m_axis_tready to fifo_rd_en.
- Sits between the RIFL FIFO/RAM storage read ports and downstream AXI-Stream consumers, in a single clock domain.

Parameters:
- DWIDTH, 32: data width of fifo_rd_data and m_axis_tdata.
- RD_LATENCY, 1: cycles from fifo_rd_en sampled high to fifo_rd_data valid. Legal values 1..3.
- BUF_DEPTH, RD_LATENCY+2: prefetch buffer entries. Local parameter, not overridable.

Ports:
- clk  input  1  single clock for all logic.
- rst_n  input  1  asynchronous, active-low reset.
- fifo_rd_en  output  1  read strobe to the upstream FIFO.
- fifo_rd_data  input  DWIDTH  upstream FIFO read data, valid RD_LATENCY cycles after fifo_rd_en.
- fifo_empty  input  1  upstream FIFO empty flag.
- m_axis_tdata  output  DWIDTH  stream data (head of the prefetch buffer).
- m_axis_tvalid  output  1  stream valid.
- m_axis_tready  input  1  stream ready.
- buf_cnt  output  $clog2(BUF_DEPTH+1)  current prefetch buffer occupancy.

Behaviour:
- Reset (rst_n low, asynchronous assert):
  - occupancy, wr/rd pointers and the in-flight pipe clear to 0.
  - m_axis_tvalid=0, buf_cnt=0, m_axis_tdata=0.
  - fifo_rd_en forced 0 combinationally for as long as rst_n is low.
- In-flight tracking:
  - shift register of RD_LATENCY bits; bit 0 loads fifo_rd_en each edge.
  - when the last bit is 1, fifo_rd_data is written into the buffer at wr_ptr on that edge.
  - inflight = popcount of the shift register.
- Read issue: fifo_rd_en = rst_n & ~fifo_empty & (buf_cnt + inflight < BUF_DEPTH).
  - Uses registered state only; the same-cycle pop is deliberately ignored.
  - BUF_DEPTH=RD_LATENCY+2 still sustains 1 beat/clk.
- Output side:
  - m_axis_tvalid = (buf_cnt != 0), from registered state.
  - m_axis_tdata = buffer entry at rd_ptr.
  - A pop occurs on tvalid & tready; rd_ptr advances.
  - tdata/tvalid are held stable while tvalid & ~tready.
- Occupancy update: buf_cnt_next = buf_cnt + capture - pop. Simultaneous capture and pop leaves the count unchanged.
- Pointers: each pointer wraps from BUF_DEPTH-1 to 0. Non-power-of-2 BUF_DEPTH uses explicit compare, not bit truncation.
- Overflow is impossible by construction; the verifier asserts buf_cnt + inflight <= BUF_DEPTH every cycle.
- Latency: first fifo_rd_en at cycle t gives m_axis_tvalid=1 at cycle t+RD_LATENCY+1.
- fifo_empty rising while reads are in flight: in-flight data is still captured and no further reads issue. Contract: the upstream FIFO must not deliver data for a read issued while empty.
- Reset mid-operation: all in-flight and buffered words are discarded. The upstream FIFO is reset in the same reset domain, so no stale capture occurs after release.
- Ordering: words leave in exactly the order read, with no duplication or loss.

Test Plan:
1. Reset behaviour (rst_n=0, fifo_empty=0) -> fifo_rd_en=0, tvalid=0, buf_cnt=0.
   - After release, the first rd_en is at cycle 0 after release; tvalid rises at cycle 2 (RD_LATENCY=1).
2. Stream, RD_LATENCY=1, FIFO preloaded with 0..99, tready=1 -> 100 beats 0..99 in order.
   - fifo_rd_en high 100 consecutive cycles; tvalid unbroken from its first rise until the last beat.
3. Backpressure, tready=0, FIFO holds 10 words -> exactly 3 reads issued then fifo_rd_en=0.
   - buf_cnt=3, tdata=0 stable.
   - Raising tready drains 0..9 in order.
4. Bursty empty: fifo_empty toggles every 2 cycles with tready random 50% -> no rd_en while empty.
   - Scoreboard matches; occupancy invariant holds.
5. RD_LATENCY=3 (BUF_DEPTH=5), tready=1, 64 words -> 1 beat/clk after a 4-cycle initial latency, 64 beats in order.
6. rst_n pulled low with 2 reads in flight and buf_cnt=2 -> outputs 0 immediately.
   - After release with a fresh FIFO of 5..7, only 5,6,7 are emitted; no stale words.
